// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding for the bit-serial adder and its bench.
// Contents:
//   state_t  ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
package serial_adder_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/serial_add_cell.sv
// serial_add_cell: combinational 1-bit full add built from two half adders and an OR.
// Ports (serial_add_cell):
//   a, b, cin  in   addend bits and carry-in
//   sum, cout  out  sum bit and carry-out
// Ports (halfadder):
//   a, b       in   addend bits
//   sum, carry out  xor and and of the inputs
module halfadder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module serial_add_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s1, c1, c2;
    halfadder u_ha0 (.a(a),  .b(b),   .sum(s1),  .carry(c1));
    halfadder u_ha1 (.a(s1), .b(cin), .sum(sum), .carry(c2));
    assign cout = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Build option: define SERIAL_ADDER_SUB_EN to add the `sub` port (a-b mode).
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only in IDLE
//   a, b   in   WIDTH-bit operands, captured on accepted start
//   cin    in   carry-in, captured on accepted start
//   sub    in   (SERIAL_ADDER_SUB_EN only) subtract: b inverted, carry forced to 1
//   busy   out  high while shifting
//   done   out  one-cycle pulse, sum/cout valid from this cycle
//   sum    out  WIDTH-bit registered result, held until next accepted start
//   cout   out  registered final carry, held like sum
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [CW-1:0] cnt;
    logic carry, s, carry_next, last, sub_en;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_en = sub;
`else
    assign sub_en = 1'b0;
`endif

    // Termination compares against WIDTH-1 rather than relying on counter wrap.
    assign last = cnt == LAST;
    assign busy = state == ST_SHIFT;
    assign done = state == ST_DONE;

    serial_add_cell u_cell (
        .a(a_sr[0]), .b(b_sr[0]), .cin(carry), .sum(s), .cout(carry_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state == ST_IDLE  ? (start ? ST_SHIFT : ST_IDLE) :
                     state == ST_SHIFT ? (last  ? ST_DONE  : ST_SHIFT) : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            a_sr  <= a;
            b_sr  <= sub_en ? ~b : b;
            carry <= sub_en | cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == ST_SHIFT) begin
            a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
            sum   <= {s, sum[WIDTH-1:1]};
            carry <= carry_next;
            cnt   <= cnt + CW'(1);
            if (last) cout <= carry_next;
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (WIDTH=8) using a result scoreboard.
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic busy, done, cout;
    logic [W-1:0] sum;
    logic [W:0] sb[$];
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one add, optionally re-pulsing start mid-shift with other operands,
    // then wait (bounded) for done and compare against the scoreboard.
    task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tc, input logic ts, input bit repulse);
        int n;
        logic [W:0] exp;
        @(negedge clk);
        a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        exp = ts ? ({1'b0, ta} + {1'b0, ~tb} + (W+1)'(1)) : ({1'b0, ta} + {1'b0, tb} + (W+1)'(tc));
`else
        exp = {1'b0, ta} + {1'b0, tb} + (W+1)'(tc);
`endif
        sb.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb; cin = ~tc;
        n = 1;
        while (!done && n < 40) begin
            if (repulse) check("busy_during_shift", 32'(busy), 32'd1);
            start = repulse && n == 3;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("latency", n, W + 1);
        check("busy_with_done", 32'(busy), 32'd0);
        if (sb.size() == 0) check("scoreboard_empty", 32'd0, 32'd1);
        else check("result", 32'({cout, sum}), 32'(sb.pop_front()));
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);
        check("idle_after_done", 32'(dut.state), 32'(ST_IDLE));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_state", 32'(dut.state), 32'(ST_IDLE));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);

        run_add(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
        check("dir_0f_01", 32'({cout, sum}), 32'h010);
        run_add(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        check("dir_ff_01", 32'({cout, sum}), 32'h100);
        run_add(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        check("dir_cin", 32'({cout, sum}), 32'h001);
        run_add(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        check("dir_repulse", 32'({cout, sum}), 32'h046);
        check("hold_sum", 32'({cout, sum}), 32'h046);

        @(negedge clk);
        a = 8'hAA; b = 8'h77; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", 32'(dut.state), 32'(ST_IDLE));
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        run_add(8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0);
        check("dir_3c_3c", 32'({cout, sum}), 32'h078);

`ifdef SERIAL_ADDER_SUB_EN
        run_add(8'd5, 8'd7, 1'b0, 1'b1, 1'b0);
        check("sub_5_7", 32'({cout, sum}), 32'h0FE);
        run_add(8'd7, 8'd5, 1'b1, 1'b1, 1'b0);
        check("sub_7_5", 32'({cout, sum}), 32'h102);
`endif

        for (int i = 0; i < 1000; i++)
            run_add(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);

        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
